// File: rtl/display_pkg.sv
// Shared scanout definitions: line-fetch FSM states and
// the fixed beam-to-pixel pipeline depth.
package display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_st_e;

    localparam int PIPE_LAT = 2;

endpackage

// File: rtl/framebuffer_scanout_if.sv
// Framebuffer read bus: request/ack address channel plus
// in-order data return of arbitrary latency.
interface framebuffer_scanout_if #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 12
);
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_ack;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;

    modport master (
        output rd_req, rd_addr,
        input  rd_ack, rd_valid, rd_data
    );

    modport slave (
        input  rd_req, rd_addr,
        output rd_ack, rd_valid, rd_data
    );
endinterface

// File: rtl/linebuffer_dp.sv
// Simple dual-port line RAM: one synchronous write port and one
// synchronous read port with 1-cycle latency; array is never reset.
module linebuffer_dp #(
    parameter int AW = 4,
    parameter int DW = 12
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);
    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/framebuffer_scanout.sv
// Double-buffered scanout: fetches line L+1 from memory while line L
// is displayed from the other bank, with a 2-cycle beam-to-pixel lag.
module framebuffer_scanout
    import display_pkg::*;
#(
    parameter int H_RES  = 640,
    parameter int V_RES  = 480,
    parameter int DATA_W = 12,
    parameter int ADDR_W = 19
) (
    input  logic                i_pix_clk,
    input  logic                i_rst,
    input  logic signed [15:0]  i_sx,
    input  logic signed [15:0]  i_sy,
    input  logic                i_hs,
    input  logic                i_vs,
    input  logic                i_de,
    output logic                o_rd_req,
    output logic [ADDR_W-1:0]   o_rd_addr,
    input  logic                i_rd_ack,
    input  logic                i_rd_valid,
    input  logic [DATA_W-1:0]   i_rd_data,
    output logic                o_hs,
    output logic                o_vs,
    output logic                o_de,
    output logic [DATA_W-1:0]   o_pix,
    output logic                o_underrun
);
    localparam int IW = $clog2(H_RES);
    localparam logic [IW-1:0] IDX_LAST = IW'(H_RES - 1);
    localparam logic [IW-1:0] IDX_ONE = IW'(1);
    localparam logic [ADDR_W-1:0] A_ONE = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_LINE = ADDR_W'(H_RES);
    localparam logic signed [15:0] SY_LAST = 16'(V_RES - 2);

    fetch_st_e         state_q;
    logic              req_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] base_d;
    logic [IW-1:0]     req_cnt_q;
    logic [IW-1:0]     wr_idx_q;
    logic              bank_q;
    logic              under_q;
    logic              trig;
    logic              wr_en;

    assign trig = (i_sx == 16'sd0) && (i_sy >= -16'sd1)
               && (i_sy <= SY_LAST);
    // Base tracks L*H_RES on every trigger, so a skipped line keeps later addresses right
    assign base_d = (i_sy == -16'sd1) ? '0 : base_q + A_LINE;
    assign wr_en = i_rd_valid && (state_q != ST_IDLE);

    always_ff @(posedge i_pix_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            req_q     <= 1'b0;
            addr_q    <= '0;
            base_q    <= '0;
            req_cnt_q <= '0;
            wr_idx_q  <= '0;
            bank_q    <= 1'b0;
            under_q   <= 1'b0;
        end else begin
            if (trig) base_q <= base_d;
            if (trig && state_q != ST_IDLE) under_q <= 1'b1;
            if (wr_en) wr_idx_q <= wr_idx_q + IDX_ONE;
            unique case (state_q)
                ST_IDLE: begin
                    if (trig) begin
                        state_q   <= ST_REQ;
                        req_q     <= 1'b1;
                        addr_q    <= base_d;
                        req_cnt_q <= '0;
                        wr_idx_q  <= '0;
                        bank_q    <= ~i_sy[0];
                    end
                end
                ST_REQ: begin
                    if (i_rd_ack) begin
                        addr_q    <= addr_q + A_ONE;
                        req_cnt_q <= req_cnt_q + IDX_ONE;
                        if (req_cnt_q == IDX_LAST) begin
                            state_q <= ST_DRAIN;
                            req_q   <= 1'b0;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (i_rd_valid && wr_idx_q == IDX_LAST)
                        state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_rd_req   = req_q;
    assign o_rd_addr  = addr_q;
    assign o_underrun = under_q;

    logic [DATA_W-1:0] rdata;
    logic              hs1_q, vs1_q, de1_q;
    logic              hs2_q, vs2_q, de2_q;
    logic [DATA_W-1:0] pix2_q;

    linebuffer_dp #(
        .AW (IW + 1),
        .DW (DATA_W)
    ) u_lb (
        .clk_i   (i_pix_clk),
        .we_i    (wr_en),
        .waddr_i ({bank_q, wr_idx_q}),
        .wdata_i (i_rd_data),
        .re_i    (i_de),
        .raddr_i ({i_sy[0], i_sx[IW-1:0]}),
        .rdata_o (rdata)
    );

    always_ff @(posedge i_pix_clk or posedge i_rst) begin
        if (i_rst) begin
            hs1_q  <= 1'b1;
            vs1_q  <= 1'b1;
            de1_q  <= 1'b0;
            hs2_q  <= 1'b1;
            vs2_q  <= 1'b1;
            de2_q  <= 1'b0;
            pix2_q <= '0;
        end else begin
            hs1_q  <= i_hs;
            vs1_q  <= i_vs;
            de1_q  <= i_de;
            hs2_q  <= hs1_q;
            vs2_q  <= vs1_q;
            de2_q  <= de1_q;
            pix2_q <= de1_q ? rdata : '0;
        end
    end

    assign o_hs  = hs2_q;
    assign o_vs  = vs2_q;
    assign o_de  = de2_q;
    assign o_pix = pix2_q;
endmodule
